// File: rtl/apb2amm_pkg.sv
// Shared definitions for the APB4 to Avalon-MM bridge: FSM state encoding
// and the Avalon response code that means success.
package apb2amm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] AMM_RSP_OKAY = 2'b00;

endpackage

// File: rtl/apb2amm_timeout.sv
// Cycle counter for the bridge's optional timeout. It counts while enabled,
// returns to zero when cleared, and flags expiry in the TO_CYCLES-th
// consecutive enabled cycle.
module apb2amm_timeout #(
  parameter int TO_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TO_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TO_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count enabled cycles; any clear restarts the window from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/apb2amm_sync.sv
// Registered APB4 slave to Avalon-MM master bridge, one transfer in flight.
// Every APB and Avalon output comes straight from a flop. Reads complete
// either at command accept or on READDATAVALID (USE_RDV). A write with no
// strobes set completes without any Avalon cycle.
// Build option: define APB2AMM_TIMEOUT_EN to abort a stalled transfer after
// TO_CYCLES cycles with PSLVERR=1; without it the bridge waits indefinitely.
module apb2amm_sync
  import apb2amm_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int USE_RDV   = 0,
  parameter int TO_CYCLES = 1024
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            APBS_PSEL,
  input  logic            APBS_PENABLE,
  input  logic [AW-1:0]   APBS_PADDR,
  input  logic            APBS_PWRITE,
  input  logic [DW-1:0]   APBS_PWDATA,
  input  logic [DW/8-1:0] APBS_PSTRB,
  output logic [DW-1:0]   APBS_PRDATA,
  output logic            APBS_PREADY,
  output logic            APBS_PSLVERR,
  output logic [AW-1:0]   AMM_ADDRESS,
  output logic [DW-1:0]   AMM_WRITEDATA,
  output logic [DW/8-1:0] AMM_BYTEENABLE,
  output logic            AMM_WRITE,
  output logic            AMM_READ,
  input  logic [DW-1:0]   AMM_READDATA,
  input  logic            AMM_WAITREQUEST,
  input  logic            AMM_READDATAVALID,
  input  logic [1:0]      AMM_RESPONSE
);

  localparam int BW = DW / 8;
  // Clears the byte-lane bits so the Avalon address is word aligned.
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(BW - 1);

  state_t state;
  logic   is_write;
  logic   busy;
  logic   timeout;

  function automatic logic rsp_err(input logic [1:0] rsp);
    return rsp != AMM_RSP_OKAY;
  endfunction

  function automatic logic [DW-1:0] rsp_data(input logic [DW-1:0] d, input logic [1:0] rsp);
    return rsp_err(rsp) ? '0 : d;
  endfunction

  assign busy = (state == ST_REQ) || (state == ST_RDWAIT);

`ifdef APB2AMM_TIMEOUT_EN
  apb2amm_timeout #(
    .TO_CYCLES(TO_CYCLES)
  ) u_timeout (
    .clk    (CLK),
    .rst_n  (RST_N),
    .clear  (!busy),
    .enable (busy),
    .expired(timeout)
  );
`else
  // No timeout counter in this build: the bridge waits indefinitely, and
  // TO_CYCLES has no effect.
  assign timeout = 1'b0 && (TO_CYCLES < 2);
`endif

  // Transfer FSM; owns every registered APB and Avalon output.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= ST_IDLE;
      is_write       <= 1'b0;
      APBS_PREADY    <= 1'b0;
      APBS_PSLVERR   <= 1'b0;
      APBS_PRDATA    <= '0;
      AMM_ADDRESS    <= '0;
      AMM_WRITEDATA  <= '0;
      AMM_BYTEENABLE <= '0;
      AMM_WRITE      <= 1'b0;
      AMM_READ       <= 1'b0;
    end else begin
      APBS_PREADY <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (APBS_PSEL && APBS_PENABLE) begin
            AMM_ADDRESS   <= APBS_PADDR & ALIGN_MASK;
            AMM_WRITEDATA <= APBS_PWDATA;
            is_write      <= APBS_PWRITE;
            if (APBS_PWRITE) begin
              AMM_BYTEENABLE <= APBS_PSTRB;
              if (APBS_PSTRB == '0) begin
                // Nothing to write: acknowledge without touching Avalon.
                state        <= ST_RESP;
                APBS_PREADY  <= 1'b1;
                APBS_PSLVERR <= 1'b0;
                APBS_PRDATA  <= '0;
              end else begin
                AMM_WRITE <= 1'b1;
                state     <= ST_REQ;
              end
            end else begin
              AMM_BYTEENABLE <= '1;
              AMM_READ       <= 1'b1;
              state          <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (!AMM_WAITREQUEST) begin
            AMM_WRITE <= 1'b0;
            AMM_READ  <= 1'b0;
            if (is_write) begin
              state        <= ST_RESP;
              APBS_PREADY  <= 1'b1;
              APBS_PSLVERR <= 1'b0;
              APBS_PRDATA  <= '0;
            end else if ((USE_RDV == 0) || AMM_READDATAVALID) begin
              // Data arrives with the accept: skip the pipelined wait.
              state        <= ST_RESP;
              APBS_PREADY  <= 1'b1;
              APBS_PSLVERR <= rsp_err(AMM_RESPONSE);
              APBS_PRDATA  <= rsp_data(AMM_READDATA, AMM_RESPONSE);
            end else begin
              state <= ST_RDWAIT;
            end
          end else if (timeout) begin
            AMM_WRITE    <= 1'b0;
            AMM_READ     <= 1'b0;
            state        <= ST_RESP;
            APBS_PREADY  <= 1'b1;
            APBS_PSLVERR <= 1'b1;
            APBS_PRDATA  <= '0;
          end
        end
        ST_RDWAIT: begin
          if (AMM_READDATAVALID) begin
            state        <= ST_RESP;
            APBS_PREADY  <= 1'b1;
            APBS_PSLVERR <= rsp_err(AMM_RESPONSE);
            APBS_PRDATA  <= rsp_data(AMM_READDATA, AMM_RESPONSE);
          end else if (timeout) begin
            state        <= ST_RESP;
            APBS_PREADY  <= 1'b1;
            APBS_PSLVERR <= 1'b1;
            APBS_PRDATA  <= '0;
          end
        end
        ST_RESP: begin
          // PREADY falls via the default above; a late READDATAVALID is ignored.
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
